// File: rtl/dm_hart_ctrl_if.sv
// Signal bundle between the debug module register logic and the hart control unit.
// The handshake is level/pulse based; there is no valid/ready pairing on this bundle.
interface dm_hart_ctrl_if;
    logic dmactive_i;
    logic haltreq_i;
    logic resumereq_i;
    logic debugging_i;
    logic debug_strobe_o;
    logic resume_req_o;
    logic halted_o;
    logic running_o;
    logic resumeack_o;
    logic halt_timeout_o;

    modport slave (
        input  dmactive_i, haltreq_i, resumereq_i, debugging_i,
        output debug_strobe_o, resume_req_o, halted_o, running_o, resumeack_o, halt_timeout_o
    );

    modport master (
        output dmactive_i, haltreq_i, resumereq_i, debugging_i,
        input  debug_strobe_o, resume_req_o, halted_o, running_o, resumeack_o, halt_timeout_o
    );
endinterface

// File: rtl/dm_hart_ctrl.sv
// Hart control: turns a level halt request into retried halt strobes with timeout,
// drives the resume request polled by the debug ROM and tracks dmstatus hart state.
module dm_hart_ctrl #(
    parameter int unsigned RETRY_CYCLES   = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    dm_hart_ctrl_if.slave      bus,
    output logic [1:0]         dbg_state_o
);
    localparam int unsigned KW = $clog2(TIMEOUT_CYCLES);
    localparam int unsigned RW = $clog2(RETRY_CYCLES);
    localparam logic [KW-1:0] K_LAST     = KW'(TIMEOUT_CYCLES - 1);
    localparam logic [KW-1:0] K_MAX      = '1;
    localparam logic [RW-1:0] RETRY_LOAD = RW'(RETRY_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RUNNING     = 2'd0,
        ST_HALT_WAIT   = 2'd1,
        ST_HALTED      = 2'd2,
        ST_RESUME_WAIT = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic [RW-1:0] retry_q, retry_d;
    logic          armed_q, armed_d;
    logic          strobe_q, strobe_d;
    logic          resume_req_q, resume_req_d;
    logic          resumeack_q, resumeack_d;
    logic          timeout_q, timeout_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_RUNNING;
            k_q          <= '0;
            retry_q      <= '0;
            armed_q      <= 1'b1;
            strobe_q     <= 1'b0;
            resume_req_q <= 1'b0;
            resumeack_q  <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            retry_q      <= retry_d;
            armed_q      <= armed_d;
            strobe_q     <= strobe_d;
            resume_req_q <= resume_req_d;
            resumeack_q  <= resumeack_d;
            timeout_q    <= timeout_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        k_d          = '0;
        retry_d      = '0;
        strobe_d     = 1'b0;
        armed_d      = bus.haltreq_i ? armed_q : 1'b1;
        resume_req_d = resume_req_q;
        resumeack_d  = resumeack_q;
        timeout_d    = timeout_q;

        if (!bus.dmactive_i) begin
            state_d      = bus.debugging_i ? ST_HALTED : ST_RUNNING;
            armed_d      = 1'b1;
            resume_req_d = 1'b0;
            resumeack_d  = 1'b0;
            timeout_d    = 1'b0;
        end else begin
            case (state_q)
                ST_RUNNING: begin
                    if (bus.debugging_i) begin
                        state_d = ST_HALTED;
                    end else if (bus.haltreq_i && armed_q) begin
                        state_d     = ST_HALT_WAIT;
                        strobe_d    = 1'b1;
                        retry_d     = RETRY_LOAD;
                        timeout_d   = 1'b0;
                        resumeack_d = 1'b0;
                    end
                end
                ST_HALT_WAIT: begin
                    // Priority: core halted, then abort, then timeout.
                    if (bus.debugging_i) begin
                        state_d = ST_HALTED;
                    end else if (!bus.haltreq_i) begin
                        state_d = ST_RUNNING;
                    end else if (k_q == K_LAST) begin
                        state_d   = ST_RUNNING;
                        timeout_d = 1'b1;
                        armed_d   = 1'b0;
                    end else begin
                        k_d      = (k_q == K_MAX) ? k_q : k_q + 1'b1;
                        retry_d  = (retry_q == '0) ? RETRY_LOAD : retry_q - 1'b1;
                        strobe_d = (retry_q == '0);
                    end
                end
                ST_HALTED: begin
                    // An unexpected debug-mode exit wins over a concurrent resume request.
                    if (!bus.debugging_i) begin
                        state_d = ST_RUNNING;
                    end else if (bus.resumereq_i && !bus.haltreq_i) begin
                        state_d      = ST_RESUME_WAIT;
                        resume_req_d = 1'b1;
                        resumeack_d  = 1'b0;
                    end
                end
                ST_RESUME_WAIT: begin
                    if (!bus.debugging_i) begin
                        state_d      = ST_RUNNING;
                        resume_req_d = 1'b0;
                        resumeack_d  = 1'b1;
                    end
                end
                default: state_d = ST_RUNNING;
            endcase
        end
    end

    always_comb begin
        bus.debug_strobe_o = strobe_q;
        bus.resume_req_o   = resume_req_q;
        bus.resumeack_o    = resumeack_q;
        bus.halt_timeout_o = timeout_q;
        bus.halted_o       = (state_q == ST_HALTED) || (state_q == ST_RESUME_WAIT);
        bus.running_o      = (state_q == ST_RUNNING) || (state_q == ST_HALT_WAIT);
        dbg_state_o        = state_q;
    end
endmodule

// File: tb/tb_dm_hart_ctrl.sv
// Bench for dm_hart_ctrl: directed scenarios with literal expectations plus
// randomized stimulus compared every cycle against a behavioural model.
module tb_dm_hart_ctrl;
    localparam int R = 4;
    localparam int T = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [1:0] dbg_state;
    always #5 clk = ~clk;

    dm_hart_ctrl_if hif();

    dm_hart_ctrl #(.RETRY_CYCLES(R), .TIMEOUT_CYCLES(T)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .bus         (hif),
        .dbg_state_o (dbg_state)
    );

    int total = 0;
    int bad = 0;
    int cyc;
    int strobe_log[$];

    always @(posedge clk or negedge rst_n)
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;

    // Behavioural model: hart halted or not, halt attempt age, pending resume.
    bit m_halted, m_trying, m_resuming, m_ack, m_to, m_armed;
    int m_k;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_halted = 0; m_trying = 0; m_resuming = 0;
            m_ack = 0; m_to = 0; m_armed = 1; m_k = 0;
        end else begin
            if (!hif.dmactive_i) begin
                m_halted = hif.debugging_i; m_trying = 0; m_resuming = 0;
                m_ack = 0; m_to = 0; m_armed = 1;
            end else if (m_resuming) begin
                if (!hif.debugging_i) begin m_halted = 0; m_resuming = 0; m_ack = 1; end
            end else if (m_halted) begin
                if (!hif.debugging_i) m_halted = 0;
                else if (hif.resumereq_i && !hif.haltreq_i) begin m_resuming = 1; m_ack = 0; end
            end else if (m_trying) begin
                if (hif.debugging_i) begin m_trying = 0; m_halted = 1; end
                else if (!hif.haltreq_i) m_trying = 0;
                else if (m_k == T - 1) begin m_trying = 0; m_to = 1; m_armed = 0; end
                else m_k = m_k + 1;
            end else begin
                if (hif.debugging_i) m_halted = 1;
                else if (hif.haltreq_i && m_armed) begin
                    m_trying = 1; m_k = 0; m_to = 0; m_ack = 0;
                end
            end
            if (!hif.haltreq_i) m_armed = 1;
        end
    end

    task automatic chk(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0b want=%0b at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic chk_str(input string name, input string act, input string exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got='%s' want='%s'", name, act, exp);
        end
    endtask

    function automatic string log_str();
        string s = "";
        foreach (strobe_log[i]) s = {s, $sformatf("%0d ", strobe_log[i])};
        return s;
    endfunction

    always @(negedge clk) begin
        if (hif.debug_strobe_o === 1'b1) strobe_log.push_back(cyc);
        chk("strobe",     hif.debug_strobe_o, m_trying && (m_k % R) == 0);
        chk("resume_req", hif.resume_req_o,   m_resuming);
        chk("halted",     hif.halted_o,       m_halted);
        chk("running",    hif.running_o,      !m_halted);
        chk("resumeack",  hif.resumeack_o,    m_ack);
        chk("timeout",    hif.halt_timeout_o, m_to);
        chk("dbg_known",  !$isunknown(dbg_state), 1'b1);
    end

    task automatic do_reset();
        rst_n = 1'b0;
        hif.dmactive_i = 1'b1; hif.haltreq_i = 1'b0;
        hif.resumereq_i = 1'b0; hif.debugging_i = 1'b0;
        @(posedge clk); #1;
        chk("rst_running", hif.running_o, 1'b1);
        chk("rst_halted",  hif.halted_o, 1'b0);
        chk("rst_strobe",  hif.debug_strobe_o, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        strobe_log.delete();
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) begin @(posedge clk); #1; end
    endtask

    initial begin
        // Basic halt
        do_reset();
        wait_to(10); hif.haltreq_i = 1;
        wait_to(13); hif.debugging_i = 1;
        wait_to(14);
        chk("basic_halted14", hif.halted_o, 1'b1);
        chk("basic_running14", hif.running_o, 1'b0);
        wait_to(16);
        chk_str("basic_strobes", log_str(), "11 ");

        // Retry
        do_reset();
        wait_to(10); hif.haltreq_i = 1;
        wait_to(20); hif.debugging_i = 1;
        wait_to(21);
        chk("retry_halted21", hif.halted_o, 1'b1);
        wait_to(24);
        chk_str("retry_strobes", log_str(), "11 15 19 ");

        // Timeout and re-arm
        do_reset();
        wait_to(10); hif.haltreq_i = 1;
        wait_to(26);
        chk("to_not_yet26", hif.halt_timeout_o, 1'b0);
        wait_to(27);
        chk("to_set27", hif.halt_timeout_o, 1'b1);
        chk("to_running27", hif.running_o, 1'b1);
        wait_to(35);
        chk_str("to_strobes", log_str(), "11 15 19 23 ");
        hif.haltreq_i = 0;
        wait_to(36); hif.haltreq_i = 1;
        wait_to(37);
        chk("rearm_strobe37", hif.debug_strobe_o, 1'b1);
        chk("rearm_to_clr37", hif.halt_timeout_o, 1'b0);
        hif.haltreq_i = 0;

        // Self-entry, then resume
        do_reset();
        wait_to(5); hif.debugging_i = 1;
        wait_to(6);
        chk("self_halted6", hif.halted_o, 1'b1);
        wait_to(30); hif.resumereq_i = 1;
        wait_to(31); hif.resumereq_i = 0;
        chk("res_req31", hif.resume_req_o, 1'b1);
        wait_to(35); hif.debugging_i = 0;
        chk("res_req35", hif.resume_req_o, 1'b1);
        wait_to(36);
        chk("res_req36", hif.resume_req_o, 1'b0);
        chk("res_ack36", hif.resumeack_o, 1'b1);
        chk("res_run36", hif.running_o, 1'b1);
        chk_str("res_strobes", log_str(), "");

        // Resume blocked by a held halt request
        do_reset();
        wait_to(5); hif.debugging_i = 1; hif.haltreq_i = 1;
        wait_to(10); hif.resumereq_i = 1;
        wait_to(11); hif.resumereq_i = 0;
        wait_to(12);
        chk("blk_halted", hif.halted_o, 1'b1);
        chk("blk_req", hif.resume_req_o, 1'b0);
        chk_str("blk_strobes", log_str(), "");
        hif.haltreq_i = 0;

        // dmactive low during resume wait
        do_reset();
        wait_to(3); hif.debugging_i = 1;
        wait_to(6); hif.resumereq_i = 1;
        wait_to(7); hif.resumereq_i = 0;
        wait_to(8);
        chk("dma_req8", hif.resume_req_o, 1'b1);
        hif.dmactive_i = 0;
        wait_to(9); hif.dmactive_i = 1;
        chk("dma_halted9", hif.halted_o, 1'b1);
        chk("dma_req9", hif.resume_req_o, 1'b0);
        chk("dma_ack9", hif.resumeack_o, 1'b0);

        // Randomized traffic with varying event rates
        do_reset();
        for (int blk = 0; blk < 30; blk++) begin
            int dbg_rate = (blk % 3 == 0) ? 3 : (blk % 3 == 1) ? 10 : 50;
            int halt_rate = (blk % 2 == 0) ? 4 : 40;
            for (int i = 0; i < 100; i++) begin
                @(posedge clk); #1;
                hif.dmactive_i  = ($urandom_range(0, 59) != 0);
                hif.resumereq_i = ($urandom_range(0, 5) == 0);
                if ($urandom_range(0, halt_rate) == 0) hif.haltreq_i = ~hif.haltreq_i;
                if ($urandom_range(0, dbg_rate) == 0) hif.debugging_i = ~hif.debugging_i;
                if (blk == 15 && i == 50) begin
                    #1 rst_n = 1'b0;
                    #5 rst_n = 1'b1;
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
